// File: rtl/mux_key_with_default_reg_if.sv
// Bus bundle for the keyed mux/register: select inputs, packed lookup list,
// write enable, and the combinational and registered results.
interface mux_key_with_default_reg_if #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 32
);
  logic [KEY_LEN-1:0]                   key;
  logic [DATA_LEN-1:0]                  default_out;
  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut;
  logic                                 wen;
  logic [DATA_LEN-1:0]                  mux_out;
  logic [DATA_LEN-1:0]                  q;

  modport master (
    output key, default_out, lut, wen,
    input  mux_out, q
  );

  modport slave (
    input  key, default_out, lut, wen,
    output mux_out, q
  );
endinterface

// File: rtl/mux_key_with_default_reg.sv
// Keyed priority mux with default word, feeding a sync-reset, write-enabled
// register. Used as next-PC select plus PC register in fetch.
module mux_key_entry #(
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 32
) (
  input  logic [KEY_LEN+DATA_LEN-1:0] entry,
  input  logic [KEY_LEN-1:0]          key,
  output logic                        hit,
  output logic [DATA_LEN-1:0]         data
);
  assign hit  = (entry[KEY_LEN+DATA_LEN-1 -: KEY_LEN] == key);
  assign data = entry[DATA_LEN-1:0];
endmodule

module mux_key_with_default_reg #(
  parameter int                  NR_KEY    = 2,
  parameter int                  KEY_LEN   = 1,
  parameter int                  DATA_LEN  = 32,
  parameter logic [DATA_LEN-1:0] RESET_VAL = 32'h8000_0000
) (
  input logic                    clk,
  input logic                    rst,
  mux_key_with_default_reg_if.slave bus
);
  localparam int P = KEY_LEN + DATA_LEN;

  logic [NR_KEY-1:0]                hit;
  logic [NR_KEY-1:0][DATA_LEN-1:0]  data;
  logic [DATA_LEN-1:0]              sel;
  logic [DATA_LEN-1:0]              q_r = RESET_VAL;

  // Entry 0 sits in the MSBs of lut, matching {key0,data0,key1,data1,...}.
  for (genvar i = 0; i < NR_KEY; i++) begin : g_entry
    mux_key_entry #(
      .KEY_LEN  (KEY_LEN),
      .DATA_LEN (DATA_LEN)
    ) u_entry (
      .entry (bus.lut[(NR_KEY-i)*P-1 -: P]),
      .key   (bus.key),
      .hit   (hit[i]),
      .data  (data[i])
    );
  end

  // Walk from the highest index down so the lowest-index hit wins.
  always_comb begin
    sel = bus.default_out;
    for (int i = NR_KEY-1; i >= 0; i--) begin
      if (hit[i]) sel = data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          q_r <= RESET_VAL;
    else if (bus.wen) q_r <= sel;
  end

  assign bus.mux_out = sel;
  assign bus.q       = q_r;
endmodule

// File: tb/tb_mux_key_with_default_reg.sv
// Random plus directed check of two configurations of the keyed mux/register
// against a table-scan reference model.
module tb_mux_key_with_default_reg;
  localparam logic [31:0] RV_A = 32'h8000_0000;
  localparam logic [15:0] RV_B = 16'hbeef;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_key_with_default_reg_if #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32)) bus_a ();
  mux_key_with_default_reg_if #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(16)) bus_b ();

  mux_key_with_default_reg #(
    .NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32), .RESET_VAL(RV_A)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  mux_key_with_default_reg #(
    .NR_KEY(3), .KEY_LEN(2), .DATA_LEN(16), .RESET_VAL(RV_B)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_tests = 0;
  int n_fail  = 0;

  logic [0:0]  ka [2];
  logic [31:0] da [2];
  logic [1:0]  kb [3];
  logic [15:0] db [3];
  logic [31:0] qa;
  logic [15:0] qb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_a(input logic [0:0] k, input logic [31:0] dflt);
    for (int i = 0; i < 2; i++) if (ka[i] == k) return da[i];
    return dflt;
  endfunction

  function automatic logic [15:0] ref_b(input logic [1:0] k, input logic [15:0] dflt);
    for (int i = 0; i < 3; i++) if (kb[i] == k) return db[i];
    return dflt;
  endfunction

  // Inputs set, check comb output and pre-edge q, take an edge, check q.
  task automatic tick(input string tag);
    logic [31:0] ea;
    logic [15:0] eb;
    bus_a.lut = {ka[0], da[0], ka[1], da[1]};
    bus_b.lut = {kb[0], db[0], kb[1], db[1], kb[2], db[2]};
    #1;
    ea = ref_a(bus_a.key, bus_a.default_out);
    eb = ref_b(bus_b.key, bus_b.default_out);
    chk({tag, ".mux_a"}, bus_a.mux_out, ea);
    chk({tag, ".mux_b"}, {16'h0, bus_b.mux_out}, {16'h0, eb});
    chk({tag, ".preq_a"}, bus_a.q, qa);
    chk({tag, ".preq_b"}, {16'h0, bus_b.q}, {16'h0, qb});
    @(posedge clk);
    if (rst) qa = RV_A; else if (bus_a.wen) qa = ea;
    if (rst) qb = RV_B; else if (bus_b.wen) qb = eb;
    #1;
    chk({tag, ".q_a"}, bus_a.q, qa);
    chk({tag, ".q_b"}, {16'h0, bus_b.q}, {16'h0, qb});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ka[0] = 1'b0; da[0] = 32'h8000_0004;
    ka[1] = 1'b1; da[1] = 32'h8000_1000;
    kb[0] = 2'd1; db[0] = 16'haaaa;
    kb[1] = 2'd1; db[1] = 16'hbbbb;
    kb[2] = 2'd2; db[2] = 16'hcccc;
    bus_a.key = 1'b0; bus_a.default_out = 32'hdead_0000; bus_a.wen = 1'b1;
    bus_b.key = 2'd0; bus_b.default_out = 16'hd00d;      bus_b.wen = 1'b1;
    qa = RV_A;
    qb = RV_B;
    #1;
    chk("init_q_a", bus_a.q, RV_A);
    chk("init_q_b", {16'h0, bus_b.q}, {16'h0, RV_B});

    // Reset held two edges with wen high
    tick("rst0");
    tick("rst1");
    chk("rst_abs", bus_a.q, 32'h8000_0000);

    // Sequential PC stepping
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      da[0] = qa + 32'd4;
      tick("seq");
    end
    chk("seq_abs", bus_a.q, 32'h8000_0008);

    // Jump then sequential
    bus_a.key = 1'b1; da[1] = 32'h8000_0100;
    tick("jump");
    chk("jump_abs", bus_a.q, 32'h8000_0100);
    bus_a.key = 1'b0; da[0] = qa + 32'd4;
    tick("post_jump");
    chk("post_jump_abs", bus_a.q, 32'h8000_0104);

    // Default and duplicate keys on the 3-entry instance
    bus_b.key = 2'd3; tick("dflt");
    chk("dflt_abs", {16'h0, bus_b.mux_out}, 32'h0000_d00d);
    bus_b.key = 2'd1; tick("dup");
    chk("dup_abs", {16'h0, bus_b.mux_out}, 32'h0000_aaaa);
    bus_b.key = 2'd2; tick("key2");
    chk("key2_abs", {16'h0, bus_b.mux_out}, 32'h0000_cccc);

    // Enable hold while mux_out moves
    bus_a.wen = 1'b0; bus_b.wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      da[0] = 32'h1000_0000 + 32'(i) * 32'h10;
      db[2] = 16'h1110 + 16'(i);
      tick("hold");
    end
    chk("hold_abs", bus_a.q, 32'h8000_0104);
    bus_a.wen = 1'b1; bus_b.wen = 1'b1;
    tick("hold_release");
    chk("release_abs", bus_a.q, 32'h1000_0020);

    // Reset beats wen on the same edge
    bus_a.key = 1'b1; da[1] = 32'h8000_0020;
    tick("pre_rst");
    rst = 1'b1;
    tick("rst_prio");
    chk("rst_prio_abs", bus_a.q, 32'h8000_0000);
    rst = 1'b0;

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 9) == 0);
      bus_a.wen = 1'($urandom);
      bus_b.wen = 1'($urandom);
      bus_a.key = 1'($urandom);
      bus_b.key = 2'($urandom);
      bus_a.default_out = $urandom;
      bus_b.default_out = 16'($urandom);
      for (int i = 0; i < 2; i++) begin
        ka[i] = 1'($urandom);
        da[i] = $urandom;
      end
      for (int i = 0; i < 3; i++) begin
        kb[i] = 2'($urandom);
        db[i] = 16'($urandom);
      end
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_key_with_default_reg.md
# mux_key_with_default_reg

Parameterised keyed multiplexer with a default value, followed by a resettable, write-enabled register. A key selects one data word from a packed lookup list. If no entry matches, a default word is chosen. The selected word is available combinationally and is captured in the register on enabled clock edges. In the fetch stage it implements next-PC selection (sequential vs. jump target) and the PC register itself.

## Interface
Parameters:
- NR_KEY, 2, number of key/data entries in the lookup list (≥1)
- KEY_LEN, 1, width of the select key and of each entry key
- DATA_LEN, 32, width of each data word, the default, and the register
- RESET_VAL, 32'h8000_0000, value loaded into the register on reset (memory base address)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous active-high reset
- key  in  KEY_LEN  select key
- default_out  in  DATA_LEN  word used when no entry key matches
- lut  in  NR_KEY*(KEY_LEN+DATA_LEN)  packed entries (packing rules below)
- wen  in  1  register write enable
- mux_out  out  DATA_LEN  combinational selected word
- q  out  DATA_LEN  registered value

## Operation
- Entry width is P = KEY_LEN+DATA_LEN. Entries are packed as a Verilog concatenation {key0,data0,key1,data1,…}, so entry 0 occupies the MSBs.
- Entry i occupies lut[(NR_KEY-i)*P-1 : (NR_KEY-1-i)*P]. Within each entry, the key is in the upper KEY_LEN bits and the data is in the lower DATA_LEN bits.
- Matching: entry i hits when its key equals `key` exactly (all bits).
- mux_out selection:
  - If at least one entry hits, mux_out is the data of the lowest-index hitting entry. Duplicate keys therefore resolve to entry 0 first, and there is no OR-merging of data words.
  - If no entry hits, mux_out = default_out.
- mux_out is purely combinational, with no latches. It has no dependence on clk, rst or wen.
- Register input is mux_out.
- Register update priority, evaluated at each rising edge:
  1. rst=1: q ← RESET_VAL, regardless of wen.
  2. Otherwise, wen=1: q ← mux_out.
  3. Otherwise: q holds.
- X/Z on `key` is not required to be handled. Simulation must not create spurious X on mux_out for fully defined inputs.

## Timing
- mux_out: zero-cycle latency. Any change on key, lut or default_out propagates within the same cycle.
- q: one-cycle latency. The value of mux_out sampled at rising edge N appears on q after edge N.
- Reset value: q = RESET_VAL after the first rising edge with rst=1. Before any edge, q is unspecified; the simulation initial value is RESET_VAL.
- Reset asserted mid-operation: it takes effect only at the next rising edge. It does not touch q asynchronously.
- On deassertion, the first edge with rst=0 and wen=1 loads mux_out.
- mux_out has no reset value; it tracks its inputs even while rst=1.
- No handshake. wen is level-sampled at each edge.

## Test plan
- Reset: rst=1 for 2 cycles, wen=1, key=0, lut={1'b0,32'h8000_0004,1'b1,32'h8000_1000} → q=32'h8000_0000 after each reset edge.
- Sequential select: rst=0, key=0, entry0 data=q+4 → q steps 0x8000_0000 → 0x8000_0004 → 0x8000_0008 on successive edges; mux_out = q+4 in each cycle.
- Jump select: key=1, entry1 data=32'h8000_0100 → mux_out=0x8000_0100 same cycle; q=0x8000_0100 after the next edge; key back to 0 gives 0x8000_0104.
- Default and duplicate keys: NR_KEY=3, KEY_LEN=2, entries keys {1,1,2} with data {A,B,C}:
  - key=3 → default_out
  - key=1 → A
  - key=2 → C
- Enable hold: wen=0 for 3 edges with a changing mux_out → q unchanged. Then wen=1 → q loads the current mux_out.
- Reset priority mid-run: q=0x8000_0020, rst=1 and wen=1 on the same edge → q=0x8000_0000. Before that edge, q is still 0x8000_0020.
